// File: rtl/half_adder_if.sv
// Operand/result bundle for the half_adder cell: operands with their qualifier,
// plus the combinational and registered results.
interface half_adder_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] c_q;
  logic             out_valid;

  // The master supplies operands and consumes results; the adder cell is the slave.
  modport master (
    output a, b, in_valid,
    input  s, c, s_q, c_q, out_valid
  );

  modport slave (
    input  a, b, in_valid,
    output s, c, s_q, c_q, out_valid
  );
endinterface : half_adder_if

// File: rtl/half_adder.sv
// Bit-parallel half adder: independent lanes, each sum = a ^ b and carry = a & b,
// with a zero-latency result and a one-cycle registered copy plus valid flag.
module half_adder #(
  parameter int WIDTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  half_adder_if.slave bus
);

  // Lane count is bounded by the 18-bit datapath this cell lives in.
  if (WIDTH < 1 || WIDTH > 18) begin : g_bad_width
    $error("half_adder: WIDTH must be in 1..18");
  end

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] carry_q;
  logic             valid_q;

  // Pure bitwise operators: no lane can influence its neighbour.
  assign sum   = bus.a ^ bus.b;
  assign carry = bus.a & bus.b;

  // NOTE: state is written with non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      // Without a new operand the last result is held; only the flag drops.
      if (bus.in_valid) begin
        sum_q   <= sum;
        carry_q <= carry;
      end
    end
  end

  assign bus.s         = sum;
  assign bus.c         = carry;
  assign bus.s_q       = sum_q;
  assign bus.c_q       = carry_q;
  assign bus.out_valid = valid_q;

endmodule : half_adder

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: one 1-lane and one 18-lane instance,
// directed vectors with hand-computed expectations plus a random invariant sweep.
module tb_half_adder;

  logic clk;
  logic rst;

  int n_checks;
  int n_failures;

  half_adder_if #(.WIDTH(1))  if1 ();
  half_adder_if #(.WIDTH(18)) if18 ();

  half_adder #(.WIDTH(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  half_adder #(.WIDTH(18)) u_dut18 (
    .clk (clk),
    .rst (rst),
    .bus (if18)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hand-computed truth table for the 1-lane sweep: {a,b} -> {s,c}.
  logic [1:0] sweep_ab [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0] sweep_sc [4] = '{2'b00, 2'b10, 2'b10, 2'b01};

  initial begin
    logic [17:0] ra, rb, exp_sq, exp_cq;
    logic        rv, exp_ov;

    n_checks   = 0;
    n_failures = 0;
    rst        = 1'b1;
    if1.a = '0;  if1.b = '0;  if1.in_valid = 1'b0;
    if18.a = '0; if18.b = '0; if18.in_valid = 1'b0;

    // Exhaustive 1-lane sweep under reset; registered side must stay cleared.
    for (int i = 0; i < 4; i++) begin
      if1.a = sweep_ab[i][1];
      if1.b = sweep_ab[i][0];
      #1;
      check($sformatf("sweep%0d_s", i), if1.s, sweep_sc[i][1]);
      check($sformatf("sweep%0d_c", i), if1.c, sweep_sc[i][0]);
      #9;
      check($sformatf("sweep%0d_sq", i), if1.s_q, 0);
      check($sformatf("sweep%0d_cq", i), if1.c_q, 0);
      check($sformatf("sweep%0d_ov", i), if1.out_valid, 0);
    end
    check("rst_ov18", if18.out_valid, 0);
    check("rst_sq18", if18.s_q, 0);

    // Release reset away from the edge, then capture 1+1.
    @(negedge clk);
    rst = 1'b0;
    if1.a = 1'b1; if1.b = 1'b1; if1.in_valid = 1'b1;
    @(posedge clk); #1;
    check("cap_sq", if1.s_q, 0);
    check("cap_cq", if1.c_q, 1);
    check("cap_ov", if1.out_valid, 1);
    if1.in_valid = 1'b0;
    if1.a = 1'b0; if1.b = 1'b1;
    @(posedge clk); #1;
    check("hold_ov", if1.out_valid, 0);
    check("hold_sq", if1.s_q, 0);
    check("hold_cq", if1.c_q, 1);

    // Load s_q=1, then reset between edges.
    if1.a = 1'b1; if1.b = 1'b0; if1.in_valid = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_sq", if1.s_q, 1);
    check("pre_rst_ov", if1.out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_sq", if1.s_q, 0);
    check("arst_cq", if1.c_q, 0);
    check("arst_ov", if1.out_valid, 0);
    check("arst_s", if1.s, 1);
    check("arst_c", if1.c, 0);
    // Edge under reset with in_valid=1 must not capture.
    @(posedge clk); #1;
    check("rst_edge_sq", if1.s_q, 0);
    check("rst_edge_ov", if1.out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("first_cap_sq", if1.s_q, 1);
    check("first_cap_ov", if1.out_valid, 1);
    if1.in_valid = 1'b0;

    // Lane independence on 18 lanes.
    if18.a = 18'h3FFFF; if18.b = 18'h00001;
    #1;
    check("lane_s", if18.s, 18'h3FFFE);
    check("lane_c", if18.c, 18'h00001);

    // Back-to-back captures.
    if18.a = 18'h2AAAA; if18.b = 18'h15555; if18.in_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b0_sq", if18.s_q, 18'h3FFFF);
    check("b2b0_cq", if18.c_q, 18'h00000);
    check("b2b0_ov", if18.out_valid, 1);
    if18.a = 18'h3FFFF; if18.b = 18'h3FFFF;
    @(posedge clk); #1;
    check("b2b1_sq", if18.s_q, 18'h00000);
    check("b2b1_cq", if18.c_q, 18'h3FFFF);
    check("b2b1_ov", if18.out_valid, 1);

    // Random sweep: combinational invariants plus a holding register model.
    exp_sq = 18'h00000;
    exp_cq = 18'h3FFFF;
    exp_ov = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      ra = 18'($urandom);
      rb = 18'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      if18.a = ra; if18.b = rb; if18.in_valid = rv;
      #1;
      check("rnd_s", if18.s, ra ^ rb);
      check("rnd_c", if18.c, ra & rb);
      check("rnd_excl", if18.s & if18.c, 0);
      @(posedge clk); #1;
      exp_ov = rv;
      if (rv) begin
        exp_sq = ra ^ rb;
        exp_cq = ra & rb;
      end
      check("rnd_ov", if18.out_valid, exp_ov);
      check("rnd_sq", if18.s_q, exp_sq);
      check("rnd_cq", if18.c_q, exp_cq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule : tb_half_adder
